// File: rtl/vc_test_mem_traffic_gen_pkg.sv
// Shared definitions for the memory traffic generator: message widths,
// message type encodings, field offsets, the sequencing state enum and a
// request-packing helper.
package vc_test_mem_pkg;

  localparam int unsigned c_req_w  = 77;
  localparam int unsigned c_resp_w = 47;

  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;

  // request {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
  localparam int unsigned c_req_data_lsb   = 0;
  localparam int unsigned c_req_len_lsb    = 32;
  localparam int unsigned c_req_addr_lsb   = 34;
  localparam int unsigned c_req_opaque_lsb = 66;
  localparam int unsigned c_req_type_lsb   = 74;

  // response {type[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
  localparam int unsigned c_resp_data_lsb   = 0;
  localparam int unsigned c_resp_len_lsb    = 32;
  localparam int unsigned c_resp_test_lsb   = 34;
  localparam int unsigned c_resp_opaque_lsb = 36;
  localparam int unsigned c_resp_type_lsb   = 44;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_WR_DRAIN = 3'd2,
    ST_RD       = 3'd3,
    ST_RD_DRAIN = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic [c_req_w-1:0] pack_req(
    input logic [2:0]  msg_type,
    input logic [7:0]  opaque,
    input logic [31:0] addr,
    input logic [1:0]  len,
    input logic [31:0] data
  );
    return {msg_type, opaque, addr, len, data};
  endfunction

endpackage

// File: rtl/vc_test_mem_traffic_gen_resp_checker.sv
// Response checker: compares an accepted response against the expected
// type/opaque/data and keeps a saturating error count.
// Ports:
//   clk, rst          clock, async active-high reset
//   clear             zero the error count (new run accepted)
//   resp_fire         a response is accepted this cycle
//   no_outstanding    nothing is in flight, so any response is unsolicited
//   check_data        compare the data field (read phase)
//   exp_*             expected type/opaque/data for this response
//   resp_*            fields of the response being accepted
//   err_count         saturating count of bad responses
module vc_test_mem_resp_checker
  import vc_test_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        resp_fire,
  input  logic        no_outstanding,
  input  logic        check_data,
  input  logic [2:0]  exp_type,
  input  logic [7:0]  exp_opaque,
  input  logic [31:0] exp_data,
  input  logic [2:0]  resp_type,
  input  logic [7:0]  resp_opaque,
  input  logic [31:0] resp_data,
  output logic [15:0] err_count
);

  logic bad_resp;

  // A response counts at most one error however many fields are wrong.
  assign bad_resp = resp_fire &&
                    (no_outstanding ||
                     (resp_type != exp_type) ||
                     (resp_opaque != exp_opaque) ||
                     (check_data && (resp_data != exp_data)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'd0;
    end else if (clear) begin
      err_count <= 16'd0;
    end else if (bad_resp && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: rtl/vc_test_mem_traffic_gen.sv
// Memory traffic generator: writes num_words words of a seed-based pattern
// starting at p_base_addr, drains, reads them all back and checks every
// response, then reports done/pass/err_count.
// Ports:
//   clk, reset                      clock, async active-high reset
//   start, seed, num_words          launch pulse and run configuration
//   memreq_val/rdy/msg              77-bit request stream out
//   memresp_val/rdy/msg             47-bit response stream in
//   busy, done, pass, err_count     run status
//
// state       | meaning
// ST_IDLE     | waiting for start after reset
// ST_WR       | issuing write requests
// ST_WR_DRAIN | all writes issued, waiting for write responses
// ST_RD       | issuing read requests
// ST_RD_DRAIN | all reads issued, waiting for read responses
// ST_DONE     | run finished, status held until next start
module vc_test_mem_traffic_gen
  import vc_test_mem_pkg::*;
#(
  parameter int unsigned p_max_outstanding = 4,
  parameter logic [31:0] p_base_addr       = 32'h0000_1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         seed,
  input  logic [15:0]         num_words,
  output logic                memreq_val,
  input  logic                memreq_rdy,
  output logic [c_req_w-1:0]  memreq_msg,
  input  logic                memresp_val,
  output logic                memresp_rdy,
  input  logic [c_resp_w-1:0] memresp_msg,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count
);

  localparam logic [7:0] c_max_out = 8'(p_max_outstanding);

  state_e      state_q, state_d;
  logic [15:0] index_q, resp_idx_q, num_words_q;
  logic [31:0] seed_q;
  logic [7:0]  outstanding_q;

  logic start_ok, can_issue, req_fire, last_fire, resp_fire, resp_counted;
  logic phase_wr, wr_drain_exit;
  logic [31:0] req_addr, req_data;
  logic unused_resp_bits;

  assign start_ok      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign can_issue     = (index_q < num_words_q) && (outstanding_q < c_max_out);
  assign req_fire      = memreq_val && memreq_rdy;
  assign last_fire     = req_fire && (index_q == (num_words_q - 16'd1));
  assign resp_fire     = memresp_val && memresp_rdy;
  // A response with nothing in flight is an error only; it must not move
  // the response index or the in-flight count.
  assign resp_counted  = resp_fire && (outstanding_q != 8'd0);
  assign phase_wr      = (state_q == ST_WR) || (state_q == ST_WR_DRAIN);
  assign wr_drain_exit = (state_q == ST_WR_DRAIN) && (outstanding_q == 8'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (num_words == 16'd0) ? ST_DONE : ST_WR;
      ST_WR:            if (last_fire) state_d = ST_WR_DRAIN;
      ST_WR_DRAIN:      if (outstanding_q == 8'd0) state_d = ST_RD;
      ST_RD:            if (last_fire) state_d = ST_RD_DRAIN;
      ST_RD_DRAIN:      if (outstanding_q == 8'd0) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_WR, ST_RD: begin
        memreq_val  = can_issue;
        memresp_rdy = 1'b1;
        busy        = 1'b1;
      end
      ST_WR_DRAIN, ST_RD_DRAIN: begin
        memresp_rdy = 1'b1;
        busy        = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && (err_count == 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q       <= 16'd0;
      resp_idx_q    <= 16'd0;
      outstanding_q <= 8'd0;
      num_words_q   <= 16'd0;
      seed_q        <= 32'd0;
    end else if (start_ok) begin
      index_q       <= 16'd0;
      resp_idx_q    <= 16'd0;
      outstanding_q <= 8'd0;
      num_words_q   <= num_words;
      seed_q        <= seed;
    end else begin
      // Read phase restarts both indices so opaque and expected data line up
      // with the write phase word numbering.
      if (wr_drain_exit) begin
        index_q    <= 16'd0;
        resp_idx_q <= 16'd0;
      end else begin
        if (req_fire)     index_q    <= index_q + 16'd1;
        if (resp_counted) resp_idx_q <= resp_idx_q + 16'd1;
      end
      unique case ({req_fire, resp_counted})
        2'b10:   outstanding_q <= outstanding_q + 8'd1;
        2'b01:   outstanding_q <= outstanding_q - 8'd1;
        default: ;
      endcase
    end
  end

  assign req_addr   = p_base_addr + {14'd0, index_q, 2'b00};
  assign req_data   = phase_wr ? (seed_q + {16'd0, index_q}) : 32'd0;
  assign memreq_msg = pack_req(phase_wr ? c_type_write : c_type_read,
                               index_q[7:0], req_addr, 2'd0, req_data);

  // test and len fields of a response carry nothing this generator checks.
  assign unused_resp_bits = ^memresp_msg[c_resp_test_lsb+1:c_resp_len_lsb];

  vc_test_mem_resp_checker u_checker (
    .clk            (clk),
    .rst            (reset),
    .clear          (start_ok),
    .resp_fire      (resp_fire),
    .no_outstanding (outstanding_q == 8'd0),
    .check_data     (!phase_wr),
    .exp_type       (phase_wr ? c_type_write : c_type_read),
    .exp_opaque     (resp_idx_q[7:0]),
    .exp_data       (seed_q + {16'd0, resp_idx_q}),
    .resp_type      (memresp_msg[c_resp_type_lsb+2:c_resp_type_lsb]),
    .resp_opaque    (memresp_msg[c_resp_opaque_lsb+7:c_resp_opaque_lsb]),
    .resp_data      (memresp_msg[c_resp_data_lsb+31:c_resp_data_lsb]),
    .err_count      (err_count)
  );

endmodule

// File: tb/tb_vc_test_mem_traffic_gen.sv
// Bench for vc_test_mem_traffic_gen: a randomized-latency memory model
// serves the DUT while directed steps check request streams and status
// against values computed from the word index, seed and base address.
module tb_vc_test_mem_traffic_gen;
  import vc_test_mem_pkg::*;

  localparam int unsigned MAXO = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] seed;
  logic [15:0] num_words;
  logic        memreq_val, memreq_rdy;
  logic [76:0] memreq_msg;
  logic        memresp_val, memresp_rdy;
  logic [46:0] memresp_msg;
  logic        busy, done, pass;
  logic [15:0] err_count;

  vc_test_mem_traffic_gen #(.p_max_outstanding(MAXO), .p_base_addr(BASE)) dut (
    .clk(clk), .reset(rst), .start(start), .seed(seed), .num_words(num_words),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model controls and state
  bit  mem_on = 0;
  int  dmax = 0;
  bit  hold_reads = 0;
  int  req_limit = 1 << 30;
  int  corrupt_word = -1;
  int  req_wait = 0;
  int  tb_out = 0;
  int  max_out = 0;
  longint cyc = 0;
  logic [76:0] req_log[$];
  typedef struct { longint due; logic [46:0] msg; bit is_read; } resp_t;
  resp_t pend[$];
  logic [31:0] mem [logic [31:0]];

  // Memory: acts exactly on the falling edge; the directed steps act 1 unit later.
  initial begin
    logic [2:0]  t;
    logic [7:0]  o;
    logic [31:0] a, d;
    resp_t       r;
    memreq_rdy = 0; memresp_val = 0; memresp_msg = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mem_on) begin
        pend.delete();
        tb_out = 0;
        continue;
      end
      memresp_val = 0;
      if (pend.size() > 0 && pend[0].due <= cyc && memresp_rdy &&
          !(hold_reads && pend[0].is_read)) begin
        memresp_val = 1;
        memresp_msg = pend[0].msg;
        void'(pend.pop_front());
        tb_out--;
      end
      memreq_rdy = (req_wait == 0) && (req_log.size() < req_limit);
      if (req_wait > 0) req_wait--;
      if (memreq_val && memreq_rdy) begin
        req_log.push_back(memreq_msg);
        t = memreq_msg[76:74];
        o = memreq_msg[73:66];
        a = memreq_msg[65:34];
        if (t == 3'd1) begin
          mem[a] = memreq_msg[31:0];
          r.msg = {3'd1, o, 2'd0, 2'd0, 32'd0};
          r.is_read = 0;
        end else begin
          d = mem.exists(a) ? mem[a] : 32'd0;
          if (int'((a - BASE) >> 2) == corrupt_word) d = d ^ 32'h1;
          r.msg = {3'd0, o, 2'd0, 2'd0, d};
          r.is_read = 1;
        end
        r.due = cyc + longint'($urandom_range(32'(dmax), 0)) + 1;
        pend.push_back(r);
        req_wait = int'($urandom_range(32'(dmax), 0));
        tb_out++;
      end
      if (tb_out > max_out) max_out = tb_out;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] sd, input logic [15:0] nw);
    tick();
    start = 1; seed = sd; num_words = nw;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int limit, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  // Request i of a phase: words are numbered from 0 in both phases.
  function automatic logic [76:0] exp_req(input int i, input bit wr, input logic [31:0] sd);
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  o;
    a = BASE + 32'(i) * 32'd4;
    d = wr ? sd + 32'(i) : 32'd0;
    o = 8'(i);
    return {(wr ? 3'd1 : 3'd0), o, a, 2'd0, d};
  endfunction

  task automatic check_log(input string tag, input int nw, input logic [31:0] sd);
    chk({tag, "_req_count"}, 128'(req_log.size()), 128'(2 * nw));
    for (int i = 0; i < 2 * nw && i < req_log.size(); i++)
      chk($sformatf("%s_req%0d", tag, i), 128'(req_log[i]),
          128'(exp_req(i % nw, i < nw, sd)));
  endtask

  initial begin
    bit to;
    logic [31:0] sd;
    rst = 1; start = 0; seed = 0; num_words = 0;
    tick(); tick();
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_memresp_rdy", memresp_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    rst = 0;
    mem_on = 1;

    // Basic run with an ideal memory
    dmax = 0; req_log.delete();
    do_start(32'h100, 16'd8);
    chk("a_issue_latency", memreq_val, 1);
    chk("a_busy", busy, 1);
    wait_done(2000, to);
    chk("a_timeout", to, 0);
    check_log("a", 8, 32'h100);
    chk("a_done", done, 1);
    chk("a_pass", pass, 1);
    chk("a_err", err_count, 0);
    chk("a_resp_rdy_done", memresp_rdy, 0);
    chk("a_busy_done", busy, 0);

    // Zero-length run
    req_log.delete();
    do_start($urandom, 16'd0);
    chk("d_done_next", done, 1);
    chk("d_pass", pass, 1);
    chk("d_busy", busy, 0);
    repeat (4) tick();
    chk("d_no_reqs", 128'(req_log.size()), 0);

    // Random delays, long run with opaque wrap
    dmax = 10; max_out = 0; req_log.delete();
    sd = $urandom;
    do_start(sd, 16'd300);
    wait_done(40000, to);
    chk("b_timeout", to, 0);
    chk("b_max_out_bounded", 128'(max_out <= MAXO), 1);
    check_log("b", 300, sd);
    chk("b_pass", pass, 1);
    chk("b_err", err_count, 0);

    // Corrupted read of word 5, plus a start pulse mid-run that must be ignored
    dmax = 3; corrupt_word = 5; req_log.delete();
    sd = $urandom;
    do_start(sd, 16'd8);
    tick(); tick();
    do_start(32'hDEAD_BEEF, 16'd0);
    chk("c_start_ignored_busy", busy, 1);
    wait_done(4000, to);
    chk("c_timeout", to, 0);
    check_log("c", 8, sd);
    chk("c_err", err_count, 1);
    chk("c_pass", pass, 0);
    chk("c_done", done, 1);
    corrupt_word = -1;

    // Reset in the read phase with three reads in flight
    dmax = 0; hold_reads = 1; req_limit = 11; req_log.delete();
    do_start($urandom, 16'd8);
    to = 1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (req_log.size() == 11 && tb_out == 3) begin
        to = 0;
        break;
      end
    end
    chk("e_reach_rd_timeout", to, 0);
    tick();
    chk("e_val_before_rst", memreq_val, 1);
    rst = 1;
    #1;
    chk("e_rst_memreq_val", memreq_val, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_memresp_rdy", memresp_rdy, 0);
    chk("e_rst_err", err_count, 0);
    mem_on = 0; memreq_rdy = 0; memresp_val = 0;
    hold_reads = 0; req_limit = 1 << 30;
    tick();
    rst = 0;
    req_log.delete();
    mem_on = 1;
    repeat (5) tick();
    chk("e_idle_no_val", memreq_val, 0);
    chk("e_idle_no_reqs", 128'(req_log.size()), 0);
    sd = $urandom;
    do_start(sd, 16'd8);
    wait_done(2000, to);
    chk("e_rerun_timeout", to, 0);
    check_log("e", 8, sd);
    chk("e_rerun_pass", pass, 1);

    // Unsolicited response while nothing is in flight
    mem_on = 0; memreq_rdy = 0; memresp_val = 0;
    tick();
    req_log.delete();
    sd = $urandom;
    do_start(sd, 16'd4);
    memresp_val = 1;
    memresp_msg = {3'd1, 8'd0, 2'd0, 2'd0, 32'd0};
    tick();
    memresp_val = 0;
    chk("f_unsolicited_err", err_count, 1);
    chk("f_still_issuing", memreq_val, 1);
    mem_on = 1;
    wait_done(2000, to);
    chk("f_timeout", to, 0);
    check_log("f", 4, sd);
    chk("f_err_final", err_count, 1);
    chk("f_pass", pass, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
